// File: rtl/deadline_scheduler.sv
// Per-guest deadline sequencer that arms the Deadline_Unit on guest switches and reports
// violations. Define VIOLATION_COUNT_EN to add per-guest saturating violation counters.
module deadline_scheduler #(
    parameter int unsigned NUM_GUESTS = 8,
    parameter int unsigned TIME_W     = 32,
    parameter int unsigned IDLE_GUEST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_guest,
    input  logic [TIME_W-1:0] cfg_budget,
    input  logic [2:0]        current_guest,
    input  logic [TIME_W-1:0] current_time,
    output logic              du_load,
    output logic              du_enable,
    output logic [TIME_W-1:0] du_deadline,
    output logic              du_overflow,
    input  logic              du_finish,
    input  logic [2:0]        du_error,
    output logic              viol_valid,
    output logic [2:0]        viol_guest,
    output logic [2:0]        viol_code,
`ifdef VIOLATION_COUNT_EN
    input  logic [2:0]        cnt_sel,
    input  logic              cnt_clr,
    output logic [7:0]        cnt_value,
`endif
    output logic              busy
);

    localparam logic [2:0] IdleId = 3'(IDLE_GUEST);

    typedef enum logic [1:0] {StIdle, StLoad, StArmed, StReport} state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] budget_q [8];
    logic [2:0]        last_guest_q;
    logic [2:0]        active_guest_q;
    logic [2:0]        viol_code_q;
    logic              pend_q;
    logic [TIME_W-1:0] du_deadline_q;
    logic              du_overflow_q;

    logic              switch_seen;
    logic              eligible;
    logic              err_seen;
    logic              load_start;
    logic [TIME_W:0]   sum;

    assign switch_seen = (current_guest != last_guest_q);
    assign err_seen    = (du_error != 3'd0);
    assign eligible    = (current_guest != IdleId) && (32'(current_guest) < NUM_GUESTS) &&
                         (budget_q[current_guest] != '0);
    assign sum         = {1'b0, current_time} + {1'b0, budget_q[current_guest]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (switch_seen && eligible) state_d = StLoad;
            end
            StLoad: state_d = StArmed;
            StArmed: begin
                if (err_seen)         state_d = StReport;
                else if (switch_seen) state_d = eligible ? StLoad : StIdle;
                else if (du_finish)   state_d = StIdle;
            end
            StReport: begin
                // A switch that arrived together with the error is carried in pend_q.
                state_d = ((switch_seen || pend_q) && eligible) ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign load_start = (state_d == StLoad);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            last_guest_q   <= IdleId;
            active_guest_q <= 3'd0;
            viol_code_q    <= 3'd0;
            pend_q         <= 1'b0;
            du_deadline_q  <= '0;
            du_overflow_q  <= 1'b0;
            for (int i = 0; i < 8; i++) budget_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            last_guest_q <= current_guest;
            pend_q       <= (state_q == StArmed) && err_seen && switch_seen;
            if (cfg_we && (32'(cfg_guest) < NUM_GUESTS)) budget_q[cfg_guest] <= cfg_budget;
            if (state_q == StArmed && err_seen) viol_code_q <= du_error;
            if (load_start) begin
                du_deadline_q  <= sum[TIME_W-1:0];
                du_overflow_q  <= sum[TIME_W];
                active_guest_q <= current_guest;
            end
        end
    end

    assign du_load     = (state_q == StLoad);
    assign du_enable   = (state_q == StLoad) || (state_q == StArmed);
    assign du_deadline = du_deadline_q;
    assign du_overflow = du_overflow_q;
    assign viol_valid  = (state_q == StReport);
    assign viol_guest  = viol_valid ? active_guest_q : 3'd0;
    assign viol_code   = viol_valid ? viol_code_q : 3'd0;
    assign busy        = du_enable;

`ifdef VIOLATION_COUNT_EN
    logic [7:0] cnt_q [8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= 8'd0;
        end else if (cnt_clr) begin
            for (int i = 0; i < 8; i++) cnt_q[i] <= 8'd0;
        end else if (viol_valid && cnt_q[active_guest_q] != 8'hFF) begin
            cnt_q[active_guest_q] <= cnt_q[active_guest_q] + 8'd1;
        end
    end

    assign cnt_value = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_deadline_scheduler.sv
// Randomised self-checking bench for deadline_scheduler against a behavioural model.
// Define VIOLATION_COUNT_EN to also exercise the violation counters.
module tb_deadline_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_guest;
    logic [31:0] cfg_budget;
    logic [2:0]  cur_guest;
    logic [31:0] cur_time;
    logic        du_load;
    logic        du_enable;
    logic [31:0] du_deadline;
    logic        du_overflow;
    logic        du_finish;
    logic [2:0]  du_error;
    logic        viol_valid;
    logic [2:0]  viol_guest;
    logic [2:0]  viol_code;
    logic        busy;
    logic [2:0]  cnt_sel;
    logic        cnt_clr;
`ifdef VIOLATION_COUNT_EN
    logic [7:0]  cnt_value;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    deadline_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_guest    (cfg_guest),
        .cfg_budget   (cfg_budget),
        .current_guest(cur_guest),
        .current_time (cur_time),
        .du_load      (du_load),
        .du_enable    (du_enable),
        .du_deadline  (du_deadline),
        .du_overflow  (du_overflow),
        .du_finish    (du_finish),
        .du_error     (du_error),
        .viol_valid   (viol_valid),
        .viol_guest   (viol_guest),
        .viol_code    (viol_code),
`ifdef VIOLATION_COUNT_EN
        .cnt_sel      (cnt_sel),
        .cnt_clr      (cnt_clr),
        .cnt_value    (cnt_value),
`endif
        .busy         (busy)
    );

    // Behavioural model: phase names, budgets and deadlines in plain arithmetic.
    string       m_phase;
    logic [31:0] m_budget [8];
    logic [2:0]  m_last, m_active, m_code;
    logic [31:0] m_deadline;
    bit          m_ovf, m_pend;
    int          m_cnt [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = "idle";
        m_last = 3'd0; m_active = 3'd0; m_code = 3'd0;
        m_deadline = 32'd0; m_ovf = 0; m_pend = 0;
        for (int i = 0; i < 8; i++) begin
            m_budget[i] = 32'd0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        bit sw, elig, go_load;
        logic [63:0] s;
        string nxt;
        sw = (cur_guest != m_last);
        elig = (cur_guest != 3'd0) && (m_budget[cur_guest] != 32'd0);
        go_load = 0;
        nxt = "idle";
        if (m_phase == "idle") go_load = sw && elig;
        else if (m_phase == "load") nxt = "armed";
        else if (m_phase == "armed") begin
            if (du_error != 3'd0) begin
                nxt = "report";
                m_code = du_error;
            end else if (sw) go_load = elig;
            else if (!du_finish) nxt = "armed";
        end else go_load = (sw || m_pend) && elig;
`ifdef VIOLATION_COUNT_EN
        if (cnt_clr) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else if (m_phase == "report" && m_cnt[m_active] < 255) m_cnt[m_active]++;
`endif
        m_pend = (m_phase == "armed") && (du_error != 3'd0) && sw;
        if (go_load) begin
            nxt = "load";
            s = 64'(cur_time) + 64'(m_budget[cur_guest]);
            m_deadline = s[31:0];
            m_ovf = (s >= 64'h1_0000_0000);
            m_active = cur_guest;
        end
        m_phase = nxt;
        m_last = cur_guest;
        if (cfg_we) m_budget[cfg_guest] = cfg_budget;
    endtask

    task automatic compare_outputs();
        bit ld, en, rep;
        ld  = (m_phase == "load");
        en  = ld || (m_phase == "armed");
        rep = (m_phase == "report");
        check("du_load", du_load, ld);
        check("du_enable", du_enable, en);
        check("busy", busy, en);
        check("du_deadline", du_deadline, m_deadline);
        check("du_overflow", du_overflow, m_ovf);
        check("viol_valid", viol_valid, rep);
        if (rep) begin
            check("viol_guest", viol_guest, m_active);
            check("viol_code", viol_code, m_code);
        end
`ifdef VIOLATION_COUNT_EN
        check("cnt_value", cnt_value, m_cnt[cnt_sel]);
`endif
    endtask

    // Apply the current inputs across one rising edge, then compare at the falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk);
        compare_outputs();
        cfg_we = 0; du_error = 3'd0; du_finish = 0; cnt_clr = 0;
    endtask

    task automatic write_budget(input logic [2:0] g, input logic [31:0] b);
        cfg_we = 1; cfg_guest = g; cfg_budget = b;
        cycle();
    endtask

    initial begin
        reset = 0; cfg_we = 0; cfg_guest = 0; cfg_budget = 0; cur_guest = 0; cur_time = 0;
        du_finish = 0; du_error = 0; cnt_sel = 0; cnt_clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_load", du_load, 0);
        check("rst_enable", du_enable, 0);
        check("rst_deadline", du_deadline, 0);
        check("rst_overflow", du_overflow, 0);
        check("rst_viol", viol_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1;

        // Basic arm: budget 20 at time 100.
        cur_time = 100;
        write_budget(3'd1, 32'd20);
        cur_guest = 1; cycle();
        check("arm_load", du_load, 1);
        check("arm_deadline", du_deadline, 120);
        check("arm_ovf", du_overflow, 0);
        check("arm_busy", busy, 1);
        cycle();
        check("arm_load_drop", du_load, 0);
        check("arm_enable_hold", du_enable, 1);

        // Wrap past 2^32.
        write_budget(3'd2, 32'h10);
        cur_time = 32'hFFFF_FFF8; cur_guest = 2; cycle();
        check("wrap_deadline", du_deadline, 32'h8);
        check("wrap_ovf", du_overflow, 1);
        cycle();
        du_finish = 1; cycle();
        check("finish_enable", du_enable, 0);
        check("finish_ovf_held", du_overflow, 1);

        // Violation on guest 3.
        cur_time = 200;
        write_budget(3'd3, 32'd50);
        cur_guest = 3; cycle();
        check("g3_ovf_clear", du_overflow, 0);
        cycle();
        du_error = 3'b010; cycle();
        check("err_valid", viol_valid, 1);
        check("err_guest", viol_guest, 3);
        check("err_code", viol_code, 3'b010);
        check("err_enable", du_enable, 0);
        cycle();
        check("err_idle_busy", busy, 0);
        check("err_idle_viol", viol_valid, 0);

        // Switches to non-eligible guests disarm without loading.
        cur_guest = 1; cycle(); cycle();
        cur_guest = 0; cycle();
        check("to_idle_enable", du_enable, 0);
        check("to_idle_load", du_load, 0);
        cur_guest = 4; cycle();
        check("to_g4_enable", du_enable, 0);
        check("to_g4_load", du_load, 0);
        check("to_g4_viol", viol_valid, 0);

        // Error and switch together: report first, then load the new guest.
        write_budget(3'd2, 32'd5);
        cur_time = 1000; cur_guest = 1; cycle(); cycle();
        du_error = 3'b001; cur_guest = 2; cycle();
        check("sim_viol", viol_valid, 1);
        check("sim_guest", viol_guest, 1);
        check("sim_code", viol_code, 1);
        cycle();
        check("sim_load", du_load, 1);
        check("sim_deadline", du_deadline, 1005);
        cycle();

`ifdef VIOLATION_COUNT_EN
        write_budget(3'd5, 32'd1);
        cnt_sel = 5;
        cur_guest = 5; cycle(); cycle();
        for (int i = 0; i < 256; i++) begin
            du_error = 3'b001; cur_guest = 0; cycle();
            cur_guest = 5; cycle();
            cycle();
        end
        check("cnt_sat", cnt_value, 255);
        du_error = 3'b100; cycle();
        cnt_clr = 1; cycle();
        check("cnt_clr", cnt_value, 0);
`endif

        // Asynchronous reset while armed.
        write_budget(3'd1, 32'd20);
        cur_guest = 1; cycle(); cycle();
        #2 reset = 0;
        #1;
        check("arst_enable", du_enable, 0);
        check("arst_busy", busy, 0);
        check("arst_deadline", du_deadline, 0);
        @(negedge clk);
        reset = 1;
        model_reset();
        cur_guest = 3; cycle();
        check("arst_table_cleared", du_load, 0);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1;
                cfg_guest = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 7))
                    0, 1:    cfg_budget = 32'd0;
                    2:       cfg_budget = $urandom;
                    default: cfg_budget = $urandom_range(1, 100);
                endcase
            end
            if ($urandom_range(0, 6) == 0) cur_guest = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) cur_time = 32'hFFFF_FFC0 + $urandom_range(0, 63);
            else cur_time = cur_time + $urandom_range(0, 4);
            if ($urandom_range(0, 14) == 0) du_error = 3'($urandom_range(1, 7));
            du_finish = ($urandom_range(0, 9) == 0);
            cnt_sel = 3'($urandom_range(0, 7));
            cnt_clr = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
